// File: rtl/writeback_unit.sv
`default_nettype none
//==============================================================================
// Module : writeback_unit -- in-order result queue retiring into the register
//          file, with forwarding lookups and an early front-end stall request.
// Rev    : 1.0
//==============================================================================
module writeback_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [INST_WIDTH-1:0] ex_instruction,
    input  logic                  rf_wr_grant,
    output logic                  rf_wr_en,
    output logic [4:0]            rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    input  logic [4:0]            fwd_rs1_addr,
    input  logic [4:0]            fwd_rs2_addr,
    output logic                  fwd_rs1_hit,
    output logic                  fwd_rs2_hit,
    output logic [DATA_WIDTH-1:0] fwd_rs1_data,
    output logic [DATA_WIDTH-1:0] fwd_rs2_data,
    output logic                  stall_req,
    output logic                  retire_valid,
    output logic [ADDR_WIDTH-1:0] retire_pc,
    output logic [31:0]           retire_count,
    output logic                  overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] idx_t;
    typedef logic [PTR_W:0]   cnt_t;

    localparam cnt_t C_STALL_LEVEL = cnt_t'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] r_res_q [DEPTH];
    logic [4:0]            r_rd_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_q  [DEPTH];

    cnt_t r_wr_ptr;
    cnt_t r_rd_ptr;
    logic r_stall;
    logic r_overflow;
    logic [31:0] r_retire_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    cnt_t w_count;
    cnt_t w_next_count;
    idx_t w_head;
    idx_t w_tail;
    logic [4:0] w_ex_rd;
    logic w_unused_inst;

    idx_t w_slot [DEPTH];
    logic w_occ  [DEPTH];

    assign w_head  = r_rd_ptr[PTR_W-1:0];
    assign w_tail  = r_wr_ptr[PTR_W-1:0];
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
    assign w_count = r_wr_ptr - r_rd_ptr;

    assign w_pop  = !w_empty && rf_wr_grant;
    // A full queue still accepts a result when the head leaves in the same cycle.
    assign w_push = ex_valid && (!w_full || w_pop);

    assign w_next_count = w_count + cnt_t'(w_push) - cnt_t'(w_pop);

    assign w_ex_rd       = ex_instruction[11:7];
    assign w_unused_inst = ^{ex_instruction[INST_WIDTH-1:12], ex_instruction[6:0]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_res_q[w_tail] <= ex_result;
            r_rd_q[w_tail]  <= w_ex_rd;
            r_pc_q[w_tail]  <= ex_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_stall        <= 1'b0;
            r_overflow     <= 1'b0;
            r_retire_count <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + cnt_t'(1);
            end
            if (w_pop) begin
                r_rd_ptr       <= r_rd_ptr + cnt_t'(1);
                r_retire_count <= r_retire_count + 32'd1;
            end
            if (ex_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            r_stall <= (w_next_count >= C_STALL_LEVEL);
        end
    end

    assign rf_wr_en     = w_pop && (r_rd_q[w_head] != 5'd0);
    assign retire_valid = w_pop;
    assign rf_wr_addr   = w_empty ? 5'd0 : r_rd_q[w_head];
    assign rf_wr_data   = w_empty ? '0 : r_res_q[w_head];
    assign retire_pc    = w_empty ? '0 : r_pc_q[w_head];
    assign retire_count = r_retire_count;
    assign overflow_err = r_overflow;
    assign stall_req    = r_stall;

    // Slot k is the k-th oldest entry counted from the head.
    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_slot
            assign w_slot[k] = w_head + idx_t'(k);
            assign w_occ[k]  = (cnt_t'(k) < w_count);
        end
    endgenerate

    // Walk oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        fwd_rs1_hit  = 1'b0;
        fwd_rs1_data = '0;
        fwd_rs2_hit  = 1'b0;
        fwd_rs2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_occ[i] && (fwd_rs1_addr != 5'd0) && (r_rd_q[w_slot[i]] == fwd_rs1_addr)) begin
                fwd_rs1_hit  = 1'b1;
                fwd_rs1_data = r_res_q[w_slot[i]];
            end
            if (w_occ[i] && (fwd_rs2_addr != 5'd0) && (r_rd_q[w_slot[i]] == fwd_rs2_addr)) begin
                fwd_rs2_hit  = 1'b1;
                fwd_rs2_data = r_res_q[w_slot[i]];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
//==============================================================================
// Module : tb_writeback_unit -- directed vector bench for writeback_unit.
// Rev    : 1.0
//==============================================================================
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_pc;
    logic [31:0] ex_instruction;
    logic        rf_wr_grant;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [4:0]  fwd_rs1_addr;
    logic [4:0]  fwd_rs2_addr;
    logic        fwd_rs1_hit;
    logic        fwd_rs2_hit;
    logic [31:0] fwd_rs1_data;
    logic [31:0] fwd_rs2_data;
    logic        stall_req;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_count;
    logic        overflow_err;

    writeback_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .DEPTH     (4)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_pc         (ex_pc),
        .ex_instruction(ex_instruction),
        .rf_wr_grant   (rf_wr_grant),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_addr    (rf_wr_addr),
        .rf_wr_data    (rf_wr_data),
        .fwd_rs1_addr  (fwd_rs1_addr),
        .fwd_rs2_addr  (fwd_rs2_addr),
        .fwd_rs1_hit   (fwd_rs1_hit),
        .fwd_rs2_hit   (fwd_rs2_hit),
        .fwd_rs1_data  (fwd_rs1_data),
        .fwd_rs2_data  (fwd_rs2_data),
        .stall_req     (stall_req),
        .retire_valid  (retire_valid),
        .retire_pc     (retire_pc),
        .retire_count  (retire_count),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    typedef logic [170:0] obs_t;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] res;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        g;
        logic [4:0]  a1;
        logic [4:0]  a2;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Field order: en, addr, data, retire_valid, retire_pc, hit1, data1, hit2, data2, stall, ovf, count
    function automatic obs_t mk(logic en, logic [4:0] wa, logic [31:0] wd, logic rv,
                                logic [31:0] rpc, logic h1, logic [31:0] d1, logic h2,
                                logic [31:0] d2, logic st, logic ov, logic [31:0] cnt);
        return {en, wa, wd, rv, rpc, h1, d1, h2, d2, st, ov, cnt};
    endfunction

    function automatic obs_t observed();
        return {rf_wr_en, rf_wr_addr, rf_wr_data, retire_valid, retire_pc,
                fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data,
                stall_req, overflow_err, retire_count};
    endfunction

    task automatic add(string n, logic v, logic [31:0] res, logic [4:0] rd, logic [31:0] pc,
                       logic g, logic [4:0] a1, logic [4:0] a2, obs_t exp);
        vec_t t;
        t.name = n; t.v = v; t.res = res; t.rd = rd; t.pc = pc;
        t.g = g; t.a1 = a1; t.a2 = a2; t.exp = exp;
        vecs.push_back(t);
    endtask

    task automatic check(string n, obs_t exp);
        obs_t act;
        act = observed();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [31:0] res, logic [4:0] rd, logic [31:0] pc,
                         logic g, logic [4:0] a1, logic [4:0] a2);
        ex_valid       = v;
        ex_result      = res;
        ex_instruction = {20'h0, rd, 7'h33};
        ex_pc          = pc;
        rf_wr_grant    = g;
        fwd_rs1_addr   = a1;
        fwd_rs2_addr   = a2;
    endtask

    task automatic run_vectors(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].res, vecs[i].rd, vecs[i].pc, vecs[i].g, vecs[i].a1, vecs[i].a2);
            #1;
            check(vecs[i].name, vecs[i].exp);
        end
    endtask

    initial begin
        obs_t z;
        z = '0;

        // Part A: single result, x0, back-pressure, forwarding, full swap
        add("idle",          0, 32'h0,    5'd0,  32'h0,   0, 5'd0,  5'd0,  z);
        add("single_push",   1, 32'h1234, 5'd5,  32'h100, 1, 5'd5,  5'd0,  z);
        add("single_write",  0, 32'h0,    5'd0,  32'h0,   1, 5'd5,  5'd0,  mk(1, 5, 32'h1234, 1, 32'h100, 1, 32'h1234, 0, 0, 0, 0, 0));
        add("x0_push",       1, 32'hDEAD, 5'd0,  32'h104, 1, 5'd0,  5'd0,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("x0_retire",     0, 32'h0,    5'd0,  32'h0,   1, 5'd0,  5'd0,  mk(0, 0, 32'hDEAD, 1, 32'h104, 0, 0, 0, 0, 0, 0, 1));
        add("bp_push_rd3",   1, 32'h33,   5'd3,  32'h108, 0, 5'd0,  5'd0,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        add("bp_push_rd4",   1, 32'h44,   5'd4,  32'h10C, 0, 5'd3,  5'd4,  mk(0, 3, 32'h33, 0, 32'h108, 1, 32'h33, 0, 0, 0, 0, 2));
        add("bp_stall",      0, 32'h0,    5'd0,  32'h0,   0, 5'd3,  5'd4,  mk(0, 3, 32'h33, 0, 32'h108, 1, 32'h33, 1, 32'h44, 1, 0, 2));
        add("bp_write_rd3",  0, 32'h0,    5'd0,  32'h0,   1, 5'd3,  5'd4,  mk(1, 3, 32'h33, 1, 32'h108, 1, 32'h33, 1, 32'h44, 1, 0, 2));
        add("bp_write_rd4",  0, 32'h0,    5'd0,  32'h0,   1, 5'd3,  5'd4,  mk(1, 4, 32'h44, 1, 32'h10C, 0, 0, 1, 32'h44, 0, 0, 3));
        add("fp_push_old",   1, 32'h11,   5'd7,  32'h110, 0, 5'd0,  5'd7,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        add("fp_push_young", 1, 32'h22,   5'd7,  32'h114, 0, 5'd0,  5'd7,  mk(0, 7, 32'h11, 0, 32'h110, 0, 0, 1, 32'h11, 0, 0, 4));
        add("fp_both",       0, 32'h0,    5'd0,  32'h0,   0, 5'd0,  5'd7,  mk(0, 7, 32'h11, 0, 32'h110, 0, 0, 1, 32'h22, 1, 0, 4));
        add("fp_pop_old",    0, 32'h0,    5'd0,  32'h0,   1, 5'd0,  5'd7,  mk(1, 7, 32'h11, 1, 32'h110, 0, 0, 1, 32'h22, 1, 0, 4));
        add("fp_pop_young",  0, 32'h0,    5'd0,  32'h0,   1, 5'd0,  5'd7,  mk(1, 7, 32'h22, 1, 32'h114, 0, 0, 1, 32'h22, 0, 0, 5));
        add("fp_empty",      0, 32'h0,    5'd0,  32'h0,   0, 5'd0,  5'd7,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        add("fs_push1",      1, 32'h91,   5'd13, 32'h300, 0, 5'd0,  5'd0,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        add("fs_push2",      1, 32'h92,   5'd14, 32'h304, 0, 5'd0,  5'd0,  mk(0, 13, 32'h91, 0, 32'h300, 0, 0, 0, 0, 0, 0, 6));
        add("fs_push3",      1, 32'h93,   5'd15, 32'h308, 0, 5'd0,  5'd0,  mk(0, 13, 32'h91, 0, 32'h300, 0, 0, 0, 0, 1, 0, 6));
        add("fs_push4",      1, 32'h94,   5'd16, 32'h30C, 0, 5'd0,  5'd0,  mk(0, 13, 32'h91, 0, 32'h300, 0, 0, 0, 0, 1, 0, 6));
        add("fs_swap",       1, 32'h95,   5'd17, 32'h310, 1, 5'd17, 5'd0,  mk(1, 13, 32'h91, 1, 32'h300, 0, 0, 0, 0, 1, 0, 6));
        add("fs_hold",       0, 32'h0,    5'd0,  32'h0,   0, 5'd17, 5'd14, mk(0, 14, 32'h92, 0, 32'h304, 1, 32'h95, 1, 32'h92, 1, 0, 7));

        // Part B (after mid-stream reset): overflow of a fresh queue
        add("ov_push1",      1, 32'h81,   5'd8,  32'h200, 0, 5'd0,  5'd0,  z);
        add("ov_push2",      1, 32'h82,   5'd9,  32'h204, 0, 5'd0,  5'd0,  mk(0, 8, 32'h81, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0));
        add("ov_push3",      1, 32'h83,   5'd10, 32'h208, 0, 5'd0,  5'd0,  mk(0, 8, 32'h81, 0, 32'h200, 0, 0, 0, 0, 1, 0, 0));
        add("ov_push4",      1, 32'h84,   5'd11, 32'h20C, 0, 5'd0,  5'd0,  mk(0, 8, 32'h81, 0, 32'h200, 0, 0, 0, 0, 1, 0, 0));
        add("ov_push5_drop", 1, 32'h85,   5'd12, 32'h210, 0, 5'd12, 5'd0,  mk(0, 8, 32'h81, 0, 32'h200, 0, 0, 0, 0, 1, 0, 0));
        add("ov_sticky",     0, 32'h0,    5'd0,  32'h0,   0, 5'd11, 5'd0,  mk(0, 8, 32'h81, 0, 32'h200, 1, 32'h84, 0, 0, 1, 1, 0));
        add("ov_ret1",       0, 32'h0,    5'd0,  32'h0,   1, 5'd12, 5'd0,  mk(1, 8, 32'h81, 1, 32'h200, 0, 0, 0, 0, 1, 1, 0));
        add("ov_ret2",       0, 32'h0,    5'd0,  32'h0,   1, 5'd12, 5'd0,  mk(1, 9, 32'h82, 1, 32'h204, 0, 0, 0, 0, 1, 1, 1));
        add("ov_ret3",       0, 32'h0,    5'd0,  32'h0,   1, 5'd12, 5'd0,  mk(1, 10, 32'h83, 1, 32'h208, 0, 0, 0, 0, 1, 1, 2));
        add("ov_ret4",       0, 32'h0,    5'd0,  32'h0,   1, 5'd12, 5'd0,  mk(1, 11, 32'h84, 1, 32'h20C, 0, 0, 0, 0, 0, 1, 3));
        add("ov_empty",      0, 32'h0,    5'd0,  32'h0,   1, 5'd12, 5'd0,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4));

        reset = 1'b1;
        drive(0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", z);
        @(negedge clk);
        reset = 1'b0;

        run_vectors(0, 21);

        // Full queue with the port granted, then reset asserted mid-cycle
        @(negedge clk);
        drive(0, 32'h0, 5'd0, 32'h0, 1, 5'd17, 5'd14);
        #1;
        check("pre_reset_write", mk(1, 14, 32'h92, 1, 32'h304, 1, 32'h95, 1, 32'h92, 1, 0, 7));
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", z);
        @(posedge clk);
        #1;
        check("reset_held", z);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_0", z);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("post_reset_%0d", c), z);
        end

        run_vectors(22, 32);

        @(negedge clk);
        drive(0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
